// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control
// Moore control FSM for a multi-cycle MIPS datapath (shared I/D memory,
// IR, A/B/ALUOut registers). Sequences R-type, lw, sw, beq and j, plus
// addi when MIPS_CTRL_ADDI_EN is defined.
//
// Ports:
//   clk, reset (async, active-low)       - clock / reset
//   OpCode[5:0]                          - IR[31:26]
//   mem_ready                            - memory completes access this cycle
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
//   RegDst, RegWrite, ALUSrcA, ALUSrcB[1:0], ALUOp[1:0], PCSource[1:0]
//                                        - datapath controls, decoded from state
//   state[3:0]                           - current state code (debug)
//   instr_done                           - pulse on the retiring cycle
//   illegal_op                           - pulse in DECODE on unknown opcode
//   instr_count[CNT_W-1:0]               - retired instructions, wraps
//
// Optional feature macro: MIPS_CTRL_ADDI_EN (addi support).

module mips_multicycle_control #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       OpCode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemToReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_IDLE   = 4'd15
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_instr_count;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Retired-instruction counter, wraps modulo 2^CNT_W
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr_count <= '0;
        end else if (instr_done) begin
            r_instr_count <= r_instr_count + CNT_W'(1);
        end
    end

    // Next-state and per-state control decode
    always_comb begin
        w_next      = S_FETCH;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_next = S_FETCH;
            end
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                // PC+4 and IR load only once the instruction word is valid
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                w_next  = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Speculative branch target into ALUOut
                ALUSrcB = 2'b11;
                case (OpCode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
`ifdef MIPS_CTRL_ADDI_EN
                    OP_ADDI:      w_next = S_ADDIEX;
`endif
                    default: begin
                        illegal_op = 1'b1;
                        w_next     = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_next  = (OpCode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                w_next  = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                MemToReg   = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
                w_next     = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                w_next  = S_RWB;
            end
            S_RWB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
                w_next      = S_FETCH;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
`ifdef MIPS_CTRL_ADDI_EN
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_next  = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
`endif
            // Unreachable codes recover to FETCH with all controls low
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    assign state       = r_state;
    assign instr_count = r_instr_count;

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
Moore FSM that sequences a multi-cycle MIPS datapath (shared instruction/data memory, IR, A/B/ALUOut registers), replacing single-cycle opcode decode with a per-state control schedule. Handles R-type, lw, sw, beq and j, plus addi when the optional feature is compiled in. Stalls on a memory-ready handshake, and reports retired-instruction count and illegal opcodes.

Parameters:
CNT_W, 32, width of retired-instruction counter (wraps modulo 2^CNT_W)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
OpCode  input  6  IR[31:26] from datapath
mem_ready  input  1  memory completes current read/write this cycle
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load if ALU Zero
IorD  output  1  memory address select: 0=PC, 1=ALUOut
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
IRWrite  output  1  instruction register load
MemToReg  output  1  register write data: 0=ALUOut, 1=MDR
RegDst  output  1  destination register: 0=rt, 1=rd
RegWrite  output  1  register file write enable
ALUSrcA  output  1  0=PC, 1=A
ALUSrcB  output  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
ALUOp  output  2  00=add, 01=sub, 10=funct-decoded
PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump target
state  output  4  current state code (debug)
instr_done  output  1  one-cycle pulse when an instruction retires
illegal_op  output  1  one-cycle pulse on undecodable opcode
instr_count  output  CNT_W  number of retired instructions

Behaviour:
- State codes: IDLE=15, FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
- While reset=0: state=IDLE, instr_count=0, and every output is 0 (IDLE decodes all controls to 0). Reset asserted mid-instruction aborts immediately; no partial write completes after reset assertion.
- IDLE -> FETCH unconditionally on the first clock after reset is released.
- Outputs are decoded combinationally from state. The only exception is that PCWrite and IRWrite in FETCH are gated by mem_ready.
- Per-state outputs; any signal not listed is 0:
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=mem_ready. Stay while mem_ready=0; go to DECODE when mem_ready=1.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by OpCode:
    - 100011 or 101011 -> MEMADR
    - 000000 -> EXEC
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 001000 -> ADDIEX (feature only)
    - any other -> FETCH, with illegal_op=1 for that DECODE cycle
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw -> MEMRD, sw -> MEMWR.
  - MEMRD: MemRead=1, IorD=1. Hold until mem_ready=1, then MEMWB.
  - MEMWB: RegDst=0, MemToReg=1, RegWrite=1. Then FETCH.
  - MEMWR: MemWrite=1, IorD=1. Hold until mem_ready=1, then FETCH.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Then RWB.
  - RWB: RegDst=1, MemToReg=0, RegWrite=1. Then FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Then FETCH.
  - JUMP: PCWrite=1, PCSource=10. Then FETCH.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Then ADDIWB.
  - ADDIWB: RegDst=0, MemToReg=0, RegWrite=1. Then FETCH.
- Retirement: instr_done=1 during the final cycle of MEMWB, RWB, BRANCH, JUMP, ADDIWB, and during MEMWR when mem_ready=1. instr_count increments on that clock edge and wraps from all-ones to 0. Illegal opcodes do not retire.
- mem_ready is ignored in all states other than FETCH, MEMRD and MEMWR. Memory strobes stay stable for the whole wait.
- Unreachable state codes (12-14) -> FETCH next cycle, with all outputs 0.
- Cycle counts with mem_ready=1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Optional Feature:
MIPS_CTRL_ADDI_EN: when defined, OpCode 001000 decodes to ADDIEX/ADDIWB as above. When undefined, ADDIEX/ADDIWB are not implemented and 001000 is treated as illegal (illegal_op pulse, return to FETCH, no retire).

Test Plan:
- Reset low 3 cycles, then release -> all outputs 0 during reset; state 15 then 0; first FETCH shows MemRead=1, IorD=0, ALUSrcB=01; instr_count=0.
- lw (100011), mem_ready tied 1 -> states 0,1,2,3,4; RegWrite=1 and MemToReg=1 in state 4; instr_done at cycle 5; instr_count=1.
- sw with mem_ready low for 3 cycles in MEMWR -> MemWrite=1 and IorD=1 held 4 cycles; no RegWrite; single instr_done on the mem_ready=1 cycle.
- FETCH with mem_ready=0 for 2 cycles -> PCWrite=IRWrite=0 while stalled; both =1 for exactly one cycle when mem_ready=1.
- OpCode 111111 -> illegal_op=1 in DECODE; next state 0; count unchanged. Repeat with 001000: addi completes (RegDst=0, RegWrite=1 in state 11) with MIPS_CTRL_ADDI_EN defined, illegal without it.
- CNT_W=4, 16 consecutive j (000010) -> PCWrite=1 and PCSource=10 each time; instr_count wraps 15 -> 0. Reset asserted mid-EXEC -> outputs drop to 0 asynchronously and count clears.
